// File: rtl/alu_result_stage.sv
// ALU result stage: a two-entry skid FIFO between the ALU and its consumer.
// Each entry holds the result word, the control code and NZCV flags derived
// from the result when the entry is written. The flags of the most recently
// popped entry are kept architecturally, and completed pops are counted
// with a saturating counter.
module alu_result_stage #(
    parameter int BITS  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  in_result,
    input  logic             in_carry,
    input  logic             in_flag,
    input  logic [3:0]       in_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_result,
    output logic [3:0]       out_control,
    output logic [3:0]       out_nzcv,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [BITS-1:0] mem_result_reg  [2];
    logic [3:0]      mem_control_reg [2];
    logic [3:0]      mem_nzcv_reg    [2];

    logic            wr_ptr_reg;
    logic            rd_ptr_reg;
    logic [1:0]      count_reg;

    logic            push_en;
    logic            pop_en;
    logic            head_sel;
    logic [3:0]      nzcv_next;

    // Handshake status depends only on registered occupancy, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);

    // A flush wins over any transfer in the same cycle.
    assign push_en = in_valid && in_ready && !clr;
    assign pop_en  = out_valid && out_ready && !clr;

    // Flags are derived once, at write time, and travel with the entry.
    assign nzcv_next = {in_result[BITS-1], (in_result == '0), in_carry, in_flag};

    // When empty the outputs show entry 0 so they are deterministic.
    assign head_sel    = out_valid ? rd_ptr_reg : 1'b0;
    assign out_result  = mem_result_reg[head_sel];
    assign out_control = mem_control_reg[head_sel];
    assign out_nzcv    = mem_nzcv_reg[head_sel];

    // Entry storage: written at the write pointer on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_result_reg[i]  <= '0;
                mem_control_reg[i] <= '0;
                mem_nzcv_reg[i]    <= '0;
            end
        end else if (push_en) begin
            mem_result_reg[wr_ptr_reg]  <= in_result;
            mem_control_reg[wr_ptr_reg] <= in_control;
            mem_nzcv_reg[wr_ptr_reg]    <= nzcv_next;
        end
    end

    // Pointers and occupancy; one-bit pointers wrap naturally from 1 to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (clr) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_en) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Architectural flags and the saturating transfer counter track pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q  <= 4'b0000;
            xfer_cnt <= '0;
        end else if (clr) begin
            flags_q  <= 4'b0000;
            xfer_cnt <= '0;
        end else if (pop_en) begin
            flags_q <= out_nzcv;
            if (xfer_cnt != CNT_MAX) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
- REQ-001: Parameter BITS, default 8, sets the data width of the result path.
- REQ-002: Parameter CNT_W, default 16, sets the width of the transfer counter.
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous, active-low.
- REQ-005: clr  input  1  synchronous flush of buffer, flags and counter.
- REQ-006: in_valid  input  1  upstream ALU result presented this cycle.
- REQ-007: in_ready  output  1  stage can accept an entry this cycle.
- REQ-008: in_result  input  BITS  ALU result word.
- REQ-009: in_carry  input  1  ALU carry out.
- REQ-010: in_flag  input  1  ALU flag output, treated as overflow (V).
- REQ-011: in_control  input  4  ALU control code of the operation.
- REQ-012: out_valid  output  1  buffered entry available downstream.
- REQ-013: out_ready  input  1  downstream accepts the entry.
- REQ-014: out_result  output  BITS  head entry result.
- REQ-015: out_control  output  4  head entry control code.
- REQ-016: out_nzcv  output  4  head entry flags {N,Z,C,V}.
- REQ-017: flags_q  output  4  architectural NZCV of the last completed transfer.
- REQ-018: xfer_cnt  output  CNT_W  number of completed output transfers.

Function
- REQ-019: The stage SHALL be a 2-entry FIFO of {result, control, nzcv}, registered on both sides.
- REQ-020: Push SHALL occur on a clock edge with in_valid=1 and in_ready=1; pop SHALL occur on a clock edge with out_valid=1 and out_ready=1.
- REQ-021: On push, N SHALL be in_result[BITS-1], Z SHALL be (in_result==0), C SHALL be in_carry, and V SHALL be in_flag; all are computed at push and stored with the entry.
- REQ-022: in_ready SHALL be 1 when occupancy<2, combinationally from registered occupancy only, with no path from out_ready.
- REQ-023: out_valid SHALL be 1 when occupancy>0; out_result, out_control and out_nzcv SHALL reflect the head entry and SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-024: Latency SHALL be 1 cycle: an entry pushed at edge t into an empty stage is visible with out_valid=1 after edge t.
- REQ-025: With occupancy 1, a simultaneous push and pop SHALL keep occupancy 1 and present the new entry as head.
- REQ-026: With occupancy 2, in_ready SHALL be 0 and no push occurs; a pop SHALL reduce occupancy to 1.
- REQ-027: With occupancy 0, pop SHALL not occur, since out_valid=0.
- REQ-028: Read and write pointers SHALL be 1 bit each and wrap 1->0.
- REQ-029: On each pop, flags_q SHALL load the popped entry's nzcv and xfer_cnt SHALL increment by 1.
- REQ-030: xfer_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
- REQ-031: clr=1 SHALL take priority over push and pop in the same cycle: occupancy, both pointers, flags_q and xfer_cnt go to 0; the cycle's input is discarded and no pop is counted.
- REQ-032: Entry storage contents SHALL be don't-care while not valid; outputs SHALL present entry 0 contents when empty.

Reset
- REQ-033: rst_n=0 SHALL immediately, without waiting for a clock edge, force occupancy=0, pointers=0, out_valid=0, in_ready=1, flags_q=4'b0000 and xfer_cnt=0.
- REQ-034: Reset asserted mid-transfer SHALL discard all buffered entries; no pop SHALL be counted.
- REQ-035: Reset release SHALL be synchronised externally; the first push is allowed on the first edge after release.

Verification
- REQ-036: Reset -> out_valid=0, in_ready=1, flags_q=0000, xfer_cnt=0, with outputs forced low before any clock edge.
- REQ-037: Push result=8'h00, carry=1, flag=0, control=4'h8 with out_ready=1 -> next cycle out_nzcv=0110, out_control=8; after pop flags_q=0110, xfer_cnt=1.
- REQ-038: Push result=8'hB0, carry=0, flag=1 -> out_nzcv=1001; push 8'h1A, carry=1 -> 0010.
- REQ-039: out_ready=0, push 3 entries back to back -> in_ready drops after 2 pushes, third is held; then out_ready=1 -> entries drain in order and xfer_cnt reaches 3.
- REQ-040: Occupancy 1 with push and pop in the same cycle -> occupancy stays 1, new head shown, order preserved.
- REQ-041: clr=1 with occupancy 2 and in_valid=1 -> next cycle out_valid=0, flags_q=0, xfer_cnt=0; also preload xfer_cnt to FFFF, then pop -> xfer_cnt stays FFFF.
